mdu_seq: RTL and testbench
==========================

# mdu_seq

Iterative RV32M multiply/divide sequencer attached to the EX stage. It accepts one M-extension operation from EX, runs a 32-iteration shift-add (multiply) or restoring-division datapath, and holds the pipeline with `stall_o` until the result is ready. It resolves divide-by-zero and signed overflow in one cycle, and it aborts cleanly on a pipeline flush.

## Interface
- No parameters; the datapath is fixed at 32 bits and 32 iterations.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start_i`  in  1  EX holds an M-extension op; kept high until the cycle `done_o` is seen
- `op_i`  in  3  funct3 as `mdu_op_t`: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `a_i`  in  32  rs1 value
- `b_i`  in  32  rs2 value
- `flush_i`  in  1  EX instruction is squashed; abort the current op
- `busy_o`  out  1  FSM is in CALC
- `done_o`  out  1  one-cycle pulse; `result_o` is valid in that cycle
- `result_o`  out  32  final rd value
- `stall_o`  out  1  combinational: `start_i & ~done_o & ~flush_i`

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - When `start_i & ~flush_i`, latch op, operand magnitudes, result signs and the special-case flag.
  - A special case goes to DONE; anything else loads the counter with 31 and goes to CALC.
- **CALC**
  - Executes one iteration per cycle; the counter decrements each cycle.
  - At counter 0, go to DONE.
- **DONE**
  - Assert `done_o` and drive the sign-corrected result, then return to IDLE.
  - A new `start_i` is accepted in the next IDLE cycle.
- **Multiply**
  - Uses a 64-bit product register {hi, lo}, with lo loaded with the multiplier.
  - Each cycle: if lo[0], add the multiplicand to hi using a 33-bit add, then shift {carry, hi, lo} right by 1.
- **Divide**
  - Uses a 33-bit remainder and a 32-bit quotient shift register.
  - Each cycle: shift left, trial-subtract the divisor, and keep the difference if it is non-negative (set the quotient bit).
- **Signs**
  - Operand magnitudes: MUL/MULH take |a| and |b|. MULHSU takes |a| with b unsigned. DIV/REM take |a| and |b|. U-ops are unsigned.
  - Product is negated (64-bit) when the operand signs differ.
  - Quotient is negated when sign(a) ≠ sign(b).
  - Remainder takes the sign of a.
- **Result select**: MUL returns product[31:0]. MULH/MULHSU/MULHU return product[63:32]. DIV/DIVU return the quotient. REM/REMU return the remainder.
- **Special cases** (resolved in IDLE, no CALC):
  - Divide by zero: quotient 0xFFFFFFFF, remainder = a, for both signed and unsigned.
  - Signed overflow (a = 0x80000000, b = 0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0.
- Operand or op changes after acceptance are ignored.
- `flush_i` in any state: next state is IDLE, `done_o` stays low for that op, and internal results are discarded. `flush_i` together with `start_i` in IDLE means the op is not accepted.

## Timing
- Reset values: state IDLE, `busy_o` 0, `done_o` 0, `result_o` 0x00000000, counter 0.
- `rst` asserted mid-op forces these values immediately, with no done pulse.
- Normal op accepted at edge t: CALC occupies cycles t+1 … t+32, and `done_o` is high in cycle t+33.
  - `stall_o` is high in cycles t … t+32 and low in t+33, so EX advances at edge t+33.
- Special case accepted at edge t: `done_o` is high in cycle t+1, and `stall_o` is high only in cycle t.
- `result_o` is registered and holds its value after DONE until the next DONE.
- Back-to-back ops: the second op's `start_i` is seen in the IDLE cycle t+34. Issue rate is one op per 34 cycles.

## Structure
- Add `mdu_op_t` (3-bit enum matching funct3) to `rv32i_types` together with a constant `MDU_ITERS = 32`. Keep the FSM state enum local.
- One sub-module, `mdu_dp`, holds the product, remainder and quotient registers plus the per-iteration add/subtract. `mdu_seq` owns the FSM, counter, sign logic, special cases and stall.

## Test plan
- MUL a=7, b=0xFFFFFFFD (−3) → `result_o` 0xFFFFFFEB; `done_o` exactly 33 cycles after acceptance; `stall_o` high for 33 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 7/2 → 3; REMU 7/2 → 1.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with `done_o` 1 cycle after acceptance. DIV 0x80000000/0xFFFFFFFF → 0x80000000; the matching REM → 0.
- `flush_i` at CALC cycle 10 → IDLE next cycle, `busy_o` low, no `done_o`. Then a new DIVU 100/7 → 14 at the nominal latency.
- Assert `rst` at CALC cycle 5 → all outputs 0 immediately. Release `rst` and hold `start_i` with MUL 3×4 → result 12.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32 types for the EX-stage M-extension unit.
// mdu_op_t mirrors funct3 so EX can cast it directly.
package rv32i_types;

    localparam int MDU_ITERS = 32;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_t;

    function automatic logic mdu_is_div(mdu_op_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/mdu_dp.sv
// Shift-add multiply / restoring divide datapath, one iteration per step.
// The *_nx outputs expose the result of the current step for the final cycle.
module mdu_dp (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] a_mag,
    input  logic [31:0] b_mag,
    output logic [63:0] prod_nx,
    output logic [31:0] rem_nx,
    output logic [31:0] quo_nx
);

    logic [63:0] prod_q, prod_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] opb_q, opb_d;
    logic        div_q, div_d;

    logic [32:0] sum;
    logic [33:0] rem_sh;
    logic [33:0] diff;
    logic [32:0] rem_it;

    always_comb begin
        sum     = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, opb_q} : 33'd0);
        prod_nx = {sum, prod_q[31:1]};
        rem_sh  = {rem_q, quo_q[31]};
        diff    = rem_sh - {2'b00, opb_q};
        // Restore on a negative trial difference.
        rem_it  = diff[33] ? rem_sh[32:0] : diff[32:0];
        rem_nx  = rem_it[31:0];
        quo_nx  = {quo_q[30:0], ~diff[33]};

        prod_d = prod_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        opb_d  = opb_q;
        div_d  = div_q;
        if (load) begin
            prod_d = {32'd0, b_mag};
            rem_d  = '0;
            quo_d  = a_mag;
            opb_d  = is_div ? b_mag : a_mag;
            div_d  = is_div;
        end else if (step) begin
            if (div_q) begin
                rem_d = rem_it;
                quo_d = quo_nx;
            end else begin
                prod_d = prod_nx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            opb_q  <= '0;
            div_q  <= 1'b0;
        end else begin
            prod_q <= prod_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            opb_q  <= opb_d;
            div_q  <= div_d;
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M sequencer: FSM, sign handling, special cases and EX stall.
// Special cases (div by zero, signed overflow) finish without iterating.
module mdu_seq
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  mdu_op_t     op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic        stall_o
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    mdu_op_t     op_q, op_d;
    logic        neg_q, neg_d;
    logic [31:0] result_q, result_d;

    logic        load, step;
    logic        a_sgn, b_sgn;
    logic [31:0] a_mag, b_mag;
    logic        div_zero, ovf;
    logic [31:0] spec_res, calc_res;
    logic [63:0] prod_nx, prod_fix;
    logic [31:0] rem_nx, quo_nx;

    mdu_dp u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .is_div (mdu_is_div(op_i)),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .prod_nx(prod_nx),
        .rem_nx (rem_nx),
        .quo_nx (quo_nx)
    );

    always_comb begin
        a_sgn = a_i[31] & (op_i inside {MDU_MUL, MDU_MULH, MDU_MULHSU,
                                        MDU_DIV, MDU_REM});
        b_sgn = b_i[31] & (op_i inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM});
        a_mag = a_sgn ? -a_i : a_i;
        b_mag = b_sgn ? -b_i : b_i;

        div_zero = mdu_is_div(op_i) & (b_i == '0);
        ovf      = (op_i inside {MDU_DIV, MDU_REM}) &
                   (a_i == 32'h8000_0000) & (b_i == 32'hFFFF_FFFF);
        if (op_i[1])
            spec_res = div_zero ? a_i : 32'd0;
        else
            spec_res = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;

        prod_fix = neg_q ? -prod_nx : prod_nx;
        unique case (op_q)
            MDU_MUL:                        calc_res = prod_fix[31:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: calc_res = prod_fix[63:32];
            MDU_DIV, MDU_DIVU:              calc_res = neg_q ? -quo_nx : quo_nx;
            default:                        calc_res = neg_q ? -rem_nx : rem_nx;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;
        load     = 1'b0;
        step     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    op_d  = op_i;
                    neg_d = op_i[1] & op_i[2] ? a_sgn : a_sgn ^ b_sgn;
                    if (div_zero || ovf) begin
                        state_d  = S_DONE;
                        result_d = spec_res;
                    end else begin
                        load    = 1'b1;
                        cnt_d   = 5'(MDU_ITERS - 1);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                step  = 1'b1;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    result_d = calc_res;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A squashed op never publishes a result.
        if (flush_i) begin
            state_d  = S_IDLE;
            result_d = result_q;
            load     = 1'b0;
            step     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= MDU_MUL;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q == S_CALC);
    assign done_o   = (state_q == S_DONE) & ~flush_i;
    assign result_o = result_q;
    assign stall_o  = start_i & ~done_o & ~flush_i;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: driver pushes expected results and done cycles,
// a negedge monitor pops and compares whenever done_o pulses.
module tb_mdu_seq;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        flush_i = 1'b0;
    mdu_op_t     op_i = MDU_MUL;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        busy_o, done_o, stall_o;
    logic [31:0] result_o;

    mdu_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .result_o(result_o),
        .stall_o (stall_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    typedef struct {
        string       name;
        mdu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] x;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   passed = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: plain 64-bit and integer arithmetic on RV32M rules.
    function automatic logic [31:0] ref_model(mdu_op_t op, logic [31:0] a,
                                              logic [31:0] b);
        int              sa;
        int              sb2;
        longint          p;
        longint unsigned pu;
        sa  = a;
        sb2 = b;
        case (op)
            MDU_MUL: begin
                p = longint'(sa) * longint'(sb2);
                return p[31:0];
            end
            MDU_MULH: begin
                p = longint'(sa) * longint'(sb2);
                return p[63:32];
            end
            MDU_MULHSU: begin
                p = longint'(sa) * longint'({32'd0, b});
                return p[63:32];
            end
            MDU_MULHU: begin
                pu = {32'd0, a} * {32'd0, b};
                return pu[63:32];
            end
            MDU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb2;
            end
            MDU_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb2;
            end
            MDU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(mdu_op_t op, logic [31:0] a, logic [31:0] b);
        if (op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU}) return 1'b0;
        if (b == 0) return 1'b1;
        return (op inside {MDU_DIV, MDU_REM}) &&
               a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Called right after a negedge with the DUT idle.
    task automatic run_op(string name, mdu_op_t op, logic [31:0] a,
                          logic [31:0] b, logic [31:0] x);
        int lat;
        int nst;
        bit seen;
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        lat     = is_special(op, a, b) ? 1 : MDU_ITERS + 1;
        sb.push_back('{x, cyc + lat, name});
        nst  = 0;
        seen = 1'b0;
        for (int k = 0; k <= MDU_ITERS + 6; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (stall_o) nst++;
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            $display("FAIL %s_timeout: got no done expected done by %0d cycles",
                     name, MDU_ITERS + 6);
        end
        chk({name, "_stall_cycles"}, nst, lat);
        start_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && done_o) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL spurious_done: got done result %h expected no done",
                         result_o);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_result"}, result_o, e.res);
                chk({e.name, "_latency"}, cyc, e.cyc);
            end
        end
    end

    vec_t dir[$] = '{
        '{"mul_neg",  MDU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{"mulh_min", MDU_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
        '{"mulhu_ff", MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{"mulhsu_ff",MDU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{"div_neg",  MDU_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
        '{"rem_neg",  MDU_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
        '{"divu_7_2", MDU_DIVU,   32'd7,          32'd2,         32'd3},
        '{"remu_7_2", MDU_REMU,   32'd7,          32'd2,         32'd1},
        '{"div_z",    MDU_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF},
        '{"rem_z",    MDU_REM,    32'd5,          32'd0,         32'd5},
        '{"divu_z",   MDU_DIVU,   32'd9,          32'd0,         32'hFFFF_FFFF},
        '{"div_ovf",  MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
        '{"rem_ovf",  MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0}
    };

    initial begin
        mdu_op_t     rop;
        logic [31:0] ra, rb;

        repeat (3) @(negedge clk);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_result", result_o, 0);
        rst = 1'b0;

        foreach (dir[i]) begin
            @(negedge clk);
            run_op(dir[i].name, dir[i].op, dir[i].a, dir[i].b, dir[i].x);
        end

        // Flush at CALC cycle 10 squashes the op.
        @(negedge clk);
        start_i = 1'b1;
        op_i    = MDU_DIVU;
        a_i     = 32'd1000;
        b_i     = 32'd3;
        repeat (10) @(negedge clk);
        chk("flush_busy_before", busy_o, 1);
        flush_i = 1'b1;
        #1;
        chk("flush_stall", stall_o, 0);
        @(negedge clk);
        flush_i = 1'b0;
        start_i = 1'b0;
        chk("flush_busy_after", busy_o, 0);
        repeat (40) @(negedge clk);
        run_op("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 32'd14);

        // Reset in CALC cycle 5 clears outputs without a done pulse.
        @(negedge clk);
        start_i = 1'b1;
        op_i    = MDU_MUL;
        a_i     = 32'd5;
        b_i     = 32'd6;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_result", result_o, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op("rst_mul_3_4", MDU_MUL, 32'd3, 32'd4, 32'd12);

        for (int n = 0; n < 40; n++) begin
            rop = mdu_op_t'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1: begin
                    ra = 32'h8000_0000;
                    rb = 32'hFFFF_FFFF;
                end
                2:       rb = $urandom_range(1, 15);
                3:       rb = -($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            @(negedge clk);
            run_op($sformatf("rnd%0d_op%0d", n, rop), rop, ra, rb,
                   ref_model(rop, ra, rb));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
